router_pkt_tx: RTL and testbench

Packet transmitter that drives the router's input port: it accepts a destination/length request and a payload stream, buffers the payload, then emits header, payload and parity bytes under `pkt_valid`, honouring the router's `busy` back-pressure. It sits between a local packet source and the router input (`data_in`/`pkt_valid`/`busy`/`err`). After each packet it watches the router's `err` for a parity-error report.

---
 rtl/router_pkt_tx.sv | 157 +++++++++++++++
 tb/tb_router_pkt_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a payload, then sends header/payload/parity to a router.
// Optional parity corruption is enabled by ROUTER_PKT_TX_PARITY_INJECT_EN.
module router_pkt_tx #(
  parameter int MAX_LEN    = 63,
  parameter int CHK_CYCLES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
  input  logic       inject_err,
  output logic       req_ready,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  input  logic       err,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int CW = $clog2(CHK_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, HDR, DATA, PAR, CHK
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    dest_q;
  logic [5:0]    len_q;
  logic [5:0]    last_idx;
  logic          inj_q;
  logic          inj_bit;
  logic [5:0]    wr_ptr_q;
  logic [5:0]    rd_ptr_q, rd_ptr_d;
  logic [7:0]    acc_q;
  logic [7:0]    hdr;
  logic [7:0]    parity;
  logic [CW-1:0] chk_q;
  logic          chk_last;
  logic          full_q;
  logic          tx_err_q;
  logic [7:0]    mem_q [MAX_LEN];
  logic [7:0]    data_d;
  logic          pv_d;
  logic          accept;
  logic          beat;

  assign accept = (state_q == IDLE) && start
                && (dest != 2'd3) && (len != 6'd0);
  assign beat     = pl_valid && pl_ready;
  assign last_idx = len_q - 6'd1;
  assign chk_last = (chk_q == CW'(CHK_CYCLES - 1));
  assign hdr      = {len_q, dest_q};

`ifdef ROUTER_PKT_TX_PARITY_INJECT_EN
  assign inj_bit = inj_q;
`else
  assign inj_bit = inj_q & 1'b0;
`endif

  assign parity = acc_q ^ hdr ^ {7'b0, inj_bit};
  assign tx_err = tx_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      data_out  <= 8'h00;
      pkt_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_out  <= data_d;
      pkt_valid <= pv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    unique case (state_q)
      IDLE: if (accept) state_d = LOAD;
      LOAD: if (full_q) state_d = HDR;
      HDR:  if (!busy) state_d = DATA;
      DATA: begin
        if (!busy) begin
          if (rd_ptr_q == last_idx) state_d = PAR;
          else rd_ptr_d = rd_ptr_q + 6'd1;
        end
      end
      PAR:  if (!busy) state_d = CHK;
      CHK:  if (chk_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered byte lane follows the next state, so it holds under busy.
  always_comb begin
    data_d    = 8'h00;
    pv_d      = 1'b0;
    req_ready = (state_q == IDLE);
    pl_ready  = (state_q == LOAD) && !full_q;
    tx_done   = (state_q == CHK) && chk_last;
    unique case (state_d)
      HDR: begin
        data_d = hdr;
        pv_d   = 1'b1;
      end
      DATA: begin
        data_d = mem_q[rd_ptr_d];
        pv_d   = 1'b1;
      end
      PAR:     data_d = parity;
      default: data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dest_q   <= 2'd0;
      len_q    <= 6'd0;
      inj_q    <= 1'b0;
      wr_ptr_q <= 6'd0;
      rd_ptr_q <= 6'd0;
      acc_q    <= 8'h00;
      full_q   <= 1'b0;
      chk_q    <= '0;
      tx_err_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      chk_q    <= (state_q == CHK) ? chk_q + CW'(1) : '0;
      if (state_q == CHK && err) tx_err_q <= 1'b1;
      if (beat) begin
        acc_q    <= acc_q ^ pl_data;
        wr_ptr_q <= wr_ptr_q + 6'd1;
        full_q   <= (wr_ptr_q == last_idx);
      end
      if (accept) begin
        dest_q   <= dest;
        len_q    <= len;
        inj_q    <= inject_err;
        wr_ptr_q <= 6'd0;
        rd_ptr_q <= 6'd0;
        acc_q    <= 8'h00;
        full_q   <= 1'b0;
        tx_err_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (beat) mem_q[wr_ptr_q] <= pl_data;
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: scoreboard bench for router_pkt_tx.
// Expected bytes are queued at load time and popped on each transfer.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] dest = 2'd0;
  logic [5:0] len = 6'd0;
  logic       inject_err = 1'b0;
  logic       req_ready;
  logic [7:0] pl_data = 8'h00;
  logic       pl_valid = 1'b0;
  logic       pl_ready;
  logic       busy = 1'b0;
  logic       err = 1'b0;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_done;
  logic       tx_err;

  int n_chk = 0;
  int n_fail = 0;
  bit rb_en = 1'b0;

  typedef struct packed {
    logic       pv;
    logic [7:0] b;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  router_pkt_tx dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .dest       (dest),
    .len        (len),
    .inject_err (inject_err),
    .req_ready  (req_ready),
    .pl_data    (pl_data),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .busy       (busy),
    .err        (err),
    .data_out   (data_out),
    .pkt_valid  (pkt_valid),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A byte moves on an edge with busy low; parity moves with pkt_valid low.
  always @(negedge clock) begin
    if (!reset && sb.size() > 0 && !busy
        && (pkt_valid || !sb[0].pv)) begin
      check("out_byte", 32'(data_out), 32'(sb[0].b));
      check("out_pv", 32'(pkt_valid), 32'(sb[0].pv));
      void'(sb.pop_front());
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (rb_en) busy = 1'($urandom_range(0, 1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic request(input logic [1:0] d,
                         input logic [5:0] l,
                         input logic inj);
    start = 1'b1;
    dest = d;
    len = l;
    inject_err = inj;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] d,
                      input logic [5:0] l,
                      input logic inj,
                      input logic [7:0] base,
                      input logic [7:0] step);
    logic [7:0] h;
    logic [7:0] p;
    logic [7:0] b;
    h = {l, d};
    p = h;
    request(d, l, inj);
    check("pl_ready_acc", 32'(pl_ready), 1);
    check("tx_err_clr", 32'(tx_err), 0);
    sb.push_back(exp_t'({1'b1, h}));
    for (int i = 0; i < int'(l); i++) begin
      b = base + 8'(i) * step;
      p = p ^ b;
      sb.push_back(exp_t'({1'b1, b}));
      pl_valid = 1'b1;
      pl_data = b;
      tick();
    end
    pl_valid = 1'b0;
`ifdef ROUTER_PKT_TX_PARITY_INJECT_EN
    p[0] = p[0] ^ inj;
`endif
    sb.push_back(exp_t'({1'b0, p}));
  endtask

  task automatic wait_done(input bit err_exit);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (tx_done !== 1'b1 && n < 400);
    check("tx_done_seen", 32'(tx_done), 1);
    check("sb_empty", 32'(sb.size()), 0);
    if (err_exit) err = 1'b1;
    @(negedge clock);
    err = 1'b0;
    check("tx_done_pulse", 32'(tx_done), 0);
    check("req_ready_end", 32'(req_ready), 1);
    tick();
  endtask

  task automatic wait_pv();
    int n;
    n = 0;
    while (pkt_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("hdr_seen", 32'(pkt_valid), 1);
  endtask

  initial begin
    int n;
    #12;
    check("rst_data", 32'(data_out), 0);
    check("rst_pv", 32'(pkt_valid), 0);
    check("rst_plr", 32'(pl_ready), 0);
    check("rst_done", 32'(tx_done), 0);
    check("rst_err", 32'(tx_err), 0);
    check("rst_reqr", 32'(req_ready), 1);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // basic packet with header latency and no-stall length
    send(2'd1, 6'd3, 1'b0, 8'h11, 8'h11);
    check("hdr_lat0", 32'(pkt_valid), 0);
    tick();
    check("hdr_lat1", 32'(pkt_valid), 1);
    check("hdr_byte", 32'(data_out), 32'h0D);
    n = 0;
    while (pkt_valid === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("pv_len", n, 4);
    wait_done(1'b0);
    check("basic_err", 32'(tx_err), 0);

    // back-pressure on the header, parity injection request
    send(2'd1, 6'd3, 1'b1, 8'h11, 8'h11);
    wait_pv();
    busy = 1'b1;
    tick();
    check("bp_hold1", 32'(data_out), 32'h0D);
    check("bp_pv1", 32'(pkt_valid), 1);
    tick();
    check("bp_hold2", 32'(data_out), 32'h0D);
    check("bp_pv2", 32'(pkt_valid), 1);
    busy = 1'b0;
    wait_done(1'b0);

    // error report early in CHK
    send(2'd1, 6'd3, 1'b0, 8'h11, 8'h11);
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    err = 1'b1;
    tick();
    err = 1'b0;
    wait_done(1'b0);
    check("err_sticky", 32'(tx_err), 1);

    // illegal requests
    request(2'd3, 6'd5, 1'b0);
    check("ill_d_reqr", 32'(req_ready), 1);
    check("ill_d_plr", 32'(pl_ready), 0);
    check("ill_d_pv", 32'(pkt_valid), 0);
    request(2'd2, 6'd0, 1'b0);
    check("ill_l_reqr", 32'(req_ready), 1);
    check("ill_l_plr", 32'(pl_ready), 0);
    tick();
    check("ill_l_pv", 32'(pkt_valid), 0);
    check("ill_err_keep", 32'(tx_err), 1);

    // err on the CHK exit cycle
    send(2'd0, 6'd2, 1'b0, 8'hA5, 8'h01);
    wait_done(1'b1);
    check("err_exit", 32'(tx_err), 1);

    // maximum length under random back-pressure
    rb_en = 1'b1;
    send(2'd2, 6'd63, 1'b0, 8'h00, 8'h01);
    wait_done(1'b0);
    rb_en = 1'b0;
    tick();
    busy = 1'b0;
    tick();

    // reset during DATA
    send(2'd0, 6'd10, 1'b0, 8'h40, 8'h03);
    wait_pv();
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_pv", 32'(pkt_valid), 0);
    check("mid_rst_data", 32'(data_out), 0);
    check("mid_rst_reqr", 32'(req_ready), 1);
    check("mid_rst_plr", 32'(pl_ready), 0);
    sb.delete();
    tick();
    check("mid_rst_done", 32'(tx_done), 0);
    reset = 1'b0;
    tick();
    send(2'd1, 6'd3, 1'b0, 8'h11, 8'h11);
    wait_done(1'b0);
    check("post_rst_err", 32'(tx_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
